// File: rtl/fpnew_rounding_arbiter_pkg.sv
// Shared FP rounding types: rounding-mode encoding and a legality helper used by
// every op group that forwards a caller-supplied rounding mode.
package fpnew_rounding_arbiter_pkg;

    localparam int unsigned RND_MODE_W = 3;

    typedef enum logic [RND_MODE_W-1:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    // One bit per encoding; set where the mode is a concrete rounding direction.
    localparam logic [7:0] RND_MODE_VALID = 8'b0011_1111;

    function automatic logic is_valid_rnd_mode(input roundmode_e mode);
        return RND_MODE_VALID[mode];
    endfunction

endpackage

// File: rtl/fpnew_rounding_arbiter_rounding.sv
// fpnew_rounding: rounds an unrounded magnitude using round/sticky bits and a
// rounding mode; also produces the exact-zero flag and the signed-zero fix-up.
module fpnew_rounding
    import fpnew_rounding_arbiter_pkg::*;
#(
    parameter int unsigned AbsWidth = 31
) (
    input  logic [AbsWidth-1:0] abs_value_i,
    input  logic                sign_i,
    input  logic [1:0]          round_sticky_bits_i,
    input  roundmode_e          rnd_mode_i,
    input  logic                effective_subtraction_i,
    output logic [AbsWidth-1:0] abs_rounded_o,
    output logic                sign_o,
    output logic                exact_zero_o
);

    logic round_up;

    // Round-up decision per mode; unknown modes never round so the output stays defined.
    always_comb begin
        round_up = 1'b0;
        case (rnd_mode_i)
            RNE: begin
                case (round_sticky_bits_i)
                    2'b00, 2'b01: round_up = 1'b0;
                    2'b10:        round_up = abs_value_i[0];
                    2'b11:        round_up = 1'b1;
                endcase
            end
            RTZ:     round_up = 1'b0;
            RDN:     round_up = (|round_sticky_bits_i) ? sign_i : 1'b0;
            RUP:     round_up = (|round_sticky_bits_i) ? ~sign_i : 1'b0;
            RMM:     round_up = round_sticky_bits_i[1];
            ROD:     round_up = ~abs_value_i[0] & (|round_sticky_bits_i);
            default: round_up = 1'b0;
        endcase
    end

    assign abs_rounded_o = abs_value_i + AbsWidth'(round_up);
    assign exact_zero_o  = (abs_value_i == '0) && (round_sticky_bits_i == 2'b00);
    // An exact zero from x - x is -0 only when rounding down.
    assign sign_o        = (exact_zero_o && effective_subtraction_i) ? (rnd_mode_i == RDN) : sign_i;

endmodule

// File: rtl/fpnew_rounding_arbiter.sv
// fpnew_rounding_arbiter: round-robin sharing of one fpnew_rounding instance
// between NumReq requesters, results tagged with requester index and caller tag.
// Optional macro FPNEW_RND_ARB_OUT_REG_EN adds a registered output stage (latency 2).
module fpnew_rounding_arbiter
    import fpnew_rounding_arbiter_pkg::*;
#(
    parameter  int unsigned NumReq   = 4,
    parameter  int unsigned AbsWidth = 31,
    parameter  int unsigned TagWidth = 4,
    localparam int unsigned IdxW     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [NumReq-1:0]            req_valid_i,
    output logic [NumReq-1:0]            req_ready_o,
    input  logic [NumReq*AbsWidth-1:0]   req_abs_i,
    input  logic [NumReq-1:0]            req_sign_i,
    input  logic [NumReq*2-1:0]          req_rs_i,
    input  logic [NumReq*3-1:0]          req_rnd_mode_i,
    input  logic [NumReq-1:0]            req_eff_sub_i,
    input  logic [NumReq*TagWidth-1:0]   req_tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [AbsWidth-1:0]          out_abs_o,
    output logic                         out_sign_o,
    output logic                         out_exact_zero_o,
    output logic                         out_inexact_o,
    output logic                         out_bad_mode_o,
    output logic [IdxW-1:0]              out_idx_o,
    output logic [TagWidth-1:0]          out_tag_o
);

    if (NumReq < 2) begin : g_numreq_check
        $error("fpnew_rounding_arbiter: NumReq must be at least 2");
    end

    typedef struct packed {
        logic [AbsWidth-1:0] abs;
        logic                sign;
        logic [1:0]          rs;
        roundmode_e          mode;
        logic                bad_mode;
        logic                eff_sub;
        logic [IdxW-1:0]     idx;
        logic [TagWidth-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic [AbsWidth-1:0] abs;
        logic                sign;
        logic                exact_zero;
        logic                inexact;
        logic                bad_mode;
        logic [IdxW-1:0]     idx;
        logic [TagWidth-1:0] tag;
    } res_t;

    logic [AbsWidth-1:0] abs_arr  [NumReq];
    logic [1:0]          rs_arr   [NumReq];
    logic [2:0]          mode_arr [NumReq];
    logic [TagWidth-1:0] tag_arr  [NumReq];

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] gnt_idx;
    logic            gnt_valid;
    int unsigned     cand;
    logic            s1_ready;
    logic            hs;
    logic            s1_valid_q;
    s1_t             s1_q;
    s1_t             s1_d;
    res_t            res_c;
    res_t            out_c;
    logic            out_valid_c;
    logic [AbsWidth-1:0] rnd_abs;
    logic            rnd_sign;
    logic            rnd_zero;

    // Unpack the flat request buses into per-requester views.
    for (genvar i = 0; i < NumReq; i++) begin : g_unpack
        assign abs_arr[i]  = req_abs_i[i*AbsWidth +: AbsWidth];
        assign rs_arr[i]   = req_rs_i[i*2 +: 2];
        assign mode_arr[i] = req_rnd_mode_i[i*3 +: 3];
        assign tag_arr[i]  = req_tag_i[i*TagWidth +: TagWidth];
    end

    // Rotate-priority encoder: first valid requester at or after ptr_q, with wrap.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = ptr_q;
        cand      = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = (32'(ptr_q) + i) % NumReq;
            if (!gnt_valid && req_valid_i[IdxW'(cand)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IdxW'(cand);
            end
        end
    end

    assign hs = rst_ni & ~flush_i & gnt_valid & s1_ready;

    // Ready only to the granted requester; suppressed during reset and flush.
    always_comb begin
        req_ready_o = '0;
        if (hs) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    // Capture the granted request; illegal rounding modes fall back to RNE.
    always_comb begin
        s1_d          = '0;
        s1_d.abs      = abs_arr[gnt_idx];
        s1_d.sign     = req_sign_i[gnt_idx];
        s1_d.rs       = rs_arr[gnt_idx];
        s1_d.bad_mode = ~is_valid_rnd_mode(roundmode_e'(mode_arr[gnt_idx]));
        s1_d.mode     = s1_d.bad_mode ? RNE : roundmode_e'(mode_arr[gnt_idx]);
        s1_d.eff_sub  = req_eff_sub_i[gnt_idx];
        s1_d.idx      = gnt_idx;
        s1_d.tag      = tag_arr[gnt_idx];
    end

    // Round-robin pointer advances past the winner on each accepted request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (hs) begin
            ptr_q <= (32'(gnt_idx) == NumReq - 1) ? '0 : gnt_idx + IdxW'(1);
        end
    end

    // Stage S1: request register feeding the shared rounder.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (flush_i) begin
            s1_valid_q <= 1'b0;
        end else if (s1_ready) begin
            s1_valid_q <= hs;
            if (hs) begin
                s1_q <= s1_d;
            end
        end
    end

    fpnew_rounding #(
        .AbsWidth (AbsWidth)
    ) i_rounding (
        .abs_value_i             (s1_q.abs),
        .sign_i                  (s1_q.sign),
        .round_sticky_bits_i     (s1_q.rs),
        .rnd_mode_i              (s1_q.mode),
        .effective_subtraction_i (s1_q.eff_sub),
        .abs_rounded_o           (rnd_abs),
        .sign_o                  (rnd_sign),
        .exact_zero_o            (rnd_zero)
    );

    // Rounded result of the S1 entry.
    always_comb begin
        res_c            = '0;
        res_c.abs        = rnd_abs;
        res_c.sign       = rnd_sign;
        res_c.exact_zero = rnd_zero;
        res_c.inexact    = |s1_q.rs;
        res_c.bad_mode   = s1_q.bad_mode;
        res_c.idx        = s1_q.idx;
        res_c.tag        = s1_q.tag;
    end

`ifdef FPNEW_RND_ARB_OUT_REG_EN
    logic s2_valid_q;
    res_t s2_q;
    logic s2_ready;

    assign s2_ready = ~s2_valid_q | out_ready_i;
    assign s1_ready = ~s1_valid_q | s2_ready;

    // Stage S2: registered rounder result.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else if (flush_i) begin
            s2_valid_q <= 1'b0;
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_q <= res_c;
            end
        end
    end

    assign out_valid_c = s2_valid_q;
    assign out_c       = s2_valid_q ? s2_q : '0;
`else
    assign s1_ready    = ~s1_valid_q | out_ready_i;
    assign out_valid_c = s1_valid_q;
    assign out_c       = s1_valid_q ? res_c : '0;
`endif

    assign out_valid_o      = out_valid_c;
    assign out_abs_o        = out_c.abs;
    assign out_sign_o       = out_c.sign;
    assign out_exact_zero_o = out_c.exact_zero;
    assign out_inexact_o    = out_c.inexact;
    assign out_bad_mode_o   = out_c.bad_mode;
    assign out_idx_o        = out_c.idx;
    assign out_tag_o        = out_c.tag;

endmodule
